poly_voice_alloc: RTL and testbench



---
 rtl/poly_voice_alloc.sv | 244 ++++++++++++++++++++++++
 tb/tb_poly_voice_alloc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_alloc.sv
// poly_voice_alloc: PS/2 byte-stream polyphonic voice allocator.
// Decodes make/break (F0) and extended (E0) scan codes, and maps note keys
// to frequency words with optional octave transpose. It assigns notes to
// NUM_VOICES slots and steals the oldest slot when every slot is busy.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   scan_code/valid   received PS/2 byte and its one-cycle strobe
//   transpose         00/11 nominal, 01 octave up, 10 octave down
//   all_off           release every voice and return decoder to idle
//   voice_freq        per-voice frequency word (1 when gate is off)
//   voice_gate        per-voice sounding flag
//   voice_key         per-voice held scan code (0 when free)
//   active_count      number of gates set
//   steal_pulse       one-cycle strobe when a voice is stolen
module poly_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int FREQ_W     = 16,
  parameter int AGE_W      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   scan_code,
  input  logic                         scan_valid,
  input  logic [1:0]                   transpose,
  input  logic                         all_off,
  output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES*8-1:0]      voice_key,
  output logic [3:0]                   active_count,
  output logic                         steal_pulse
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BREAK,
    S_EXT,
    S_EXT_BREAK
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_make;
  logic w_release;

  logic [11:0]       w_tab_raw;
  logic              w_mapped;
  logic [FREQ_W-1:0] w_base;
  logic [FREQ_W-1:0] w_freq_new;

  logic [NUM_VOICES-1:0] r_gate;
  logic [FREQ_W-1:0]     r_freq [NUM_VOICES];
  logic [7:0]            r_key  [NUM_VOICES];
  logic [AGE_W-1:0]      r_age  [NUM_VOICES];
  logic [3:0]            r_count;
  logic                  r_steal;

  logic [NUM_VOICES-1:0] w_gate_nxt;
  logic [FREQ_W-1:0]     w_freq_nxt [NUM_VOICES];
  logic [7:0]            w_key_nxt  [NUM_VOICES];
  logic [AGE_W-1:0]      w_age_nxt  [NUM_VOICES];
  logic [3:0]            w_count_nxt;
  logic                  w_steal_nxt;

  logic             w_hit;
  logic             w_free_found;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_old_idx;
  logic [AGE_W-1:0] w_old_age;
  logic [IDX_W-1:0] w_alloc_idx;

  // Note table; 0 marks an unmapped code.
  function automatic logic [11:0] note_freq(input logic [7:0] code);
    case (code)
      8'h15: note_freq = 12'd400;
      8'h1C: note_freq = 12'd423;
      8'h1D: note_freq = 12'd448;
      8'h1B: note_freq = 12'd475;
      8'h24: note_freq = 12'd503;
      8'h23: note_freq = 12'd533;
      8'h2B: note_freq = 12'd565;
      8'h2C: note_freq = 12'd599;
      8'h34: note_freq = 12'd634;
      8'h35: note_freq = 12'd672;
      8'h33: note_freq = 12'd712;
      8'h3B: note_freq = 12'd755;
      8'h43: note_freq = 12'd800;
      8'h42: note_freq = 12'd847;
      8'h44: note_freq = 12'd897;
      8'h4B: note_freq = 12'd951;
      8'h4D: note_freq = 12'd1007;
      8'h4C: note_freq = 12'd1067;
      8'h52: note_freq = 12'd1131;
      8'h5B: note_freq = 12'd1198;
      default: note_freq = 12'd0;
    endcase
  endfunction

  always_comb begin
    w_tab_raw = note_freq(scan_code);
    w_mapped  = |w_tab_raw;
    w_base    = FREQ_W'(w_tab_raw);
    case (transpose)
      2'b01:   w_freq_new = w_base << 1;
      2'b10:   w_freq_new = w_base >> 1;
      default: w_freq_new = w_base;
    endcase
  end

  // Decoder: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Decoder: next state and events
  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_release   = 1'b0;
    if (all_off) begin
      w_state_nxt = S_IDLE;
    end else if (scan_valid) begin
      case (r_state)
        S_IDLE: begin
          if (scan_code == 8'hF0)      w_state_nxt = S_BREAK;
          else if (scan_code == 8'hE0) w_state_nxt = S_EXT;
          else if (w_mapped)           w_make = 1'b1;
        end
        S_BREAK: begin
          if (scan_code == 8'hF0) begin
            w_state_nxt = S_BREAK;
          end else if (scan_code == 8'hE0) begin
            w_state_nxt = S_EXT_BREAK;
          end else begin
            w_release   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_EXT: begin
          if (scan_code == 8'hF0) w_state_nxt = S_EXT_BREAK;
          else                    w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Voice search: repeat hit, lowest free slot, oldest slot (ties to lowest index)
  always_comb begin
    w_hit        = 1'b0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_old_idx    = '0;
    w_old_age    = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (r_gate[i] && (r_key[i] == scan_code)) w_hit = 1'b1;
      if (!r_gate[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (r_age[i] > w_old_age) begin
        w_old_age = r_age[i];
        w_old_idx = IDX_W'(i);
      end
    end
    w_alloc_idx = w_free_found ? w_free_idx : w_old_idx;
  end

  // Voice next-state
  always_comb begin
    w_gate_nxt  = r_gate;
    w_steal_nxt = 1'b0;
    w_count_nxt = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      w_freq_nxt[i] = r_freq[i];
      w_key_nxt[i]  = r_key[i];
      w_age_nxt[i]  = r_age[i];
      if (all_off) begin
        w_gate_nxt[i] = 1'b0;
        w_freq_nxt[i] = FREQ_W'(1);
        w_key_nxt[i]  = '0;
        w_age_nxt[i]  = '0;
      end else if (w_release) begin
        if (r_gate[i] && (r_key[i] == scan_code)) begin
          w_gate_nxt[i] = 1'b0;
          w_freq_nxt[i] = FREQ_W'(1);
          w_key_nxt[i]  = '0;
          w_age_nxt[i]  = '0;
        end
      end else if (w_make && !w_hit) begin
        if (IDX_W'(i) == w_alloc_idx) begin
          w_gate_nxt[i] = 1'b1;
          w_freq_nxt[i] = w_freq_new;
          w_key_nxt[i]  = scan_code;
          w_age_nxt[i]  = '0;
        end else if (r_gate[i] && (r_age[i] != '1)) begin
          w_age_nxt[i] = r_age[i] + AGE_W'(1);
        end
      end
    end
    if (!all_off && w_make && !w_hit && !w_free_found) w_steal_nxt = 1'b1;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      w_count_nxt = w_count_nxt + 4'(w_gate_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gate  <= '0;
      r_count <= '0;
      r_steal <= 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        r_freq[i] <= FREQ_W'(1);
        r_key[i]  <= '0;
        r_age[i]  <= '0;
      end
    end else begin
      r_gate  <= w_gate_nxt;
      r_count <= w_count_nxt;
      r_steal <= w_steal_nxt;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        r_freq[i] <= w_freq_nxt[i];
        r_key[i]  <= w_key_nxt[i];
        r_age[i]  <= w_age_nxt[i];
      end
    end
  end

  always_comb begin
    voice_freq = '0;
    voice_key  = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      voice_freq[i*FREQ_W +: FREQ_W] = r_freq[i];
      voice_key[i*8 +: 8]            = r_key[i];
    end
    voice_gate   = r_gate;
    active_count = r_count;
    steal_pulse  = r_steal;
  end

endmodule

// File: tb/tb_poly_voice_alloc.sv
module tb_poly_voice_alloc;

  localparam int NV = 4;
  localparam int FW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      scan_code = '0;
  logic            scan_valid = 1'b0;
  logic [1:0]      transpose = 2'b00;
  logic            all_off = 1'b0;
  logic [NV*FW-1:0] voice_freq;
  logic [NV-1:0]   voice_gate;
  logic [NV*8-1:0] voice_key;
  logic [3:0]      active_count;
  logic            steal_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  poly_voice_alloc #(.NUM_VOICES(NV), .FREQ_W(FW), .AGE_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .scan_code    (scan_code),
    .scan_valid   (scan_valid),
    .transpose    (transpose),
    .all_off      (all_off),
    .voice_freq   (voice_freq),
    .voice_gate   (voice_gate),
    .voice_key    (voice_key),
    .active_count (active_count),
    .steal_pulse  (steal_pulse)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [FW-1:0] vf(input int i);
    return voice_freq[i*FW +: FW];
  endfunction

  function automatic logic [7:0] vk(input int i);
    return voice_key[i*8 +: 8];
  endfunction

  // Byte is presented for exactly one rising edge; returns at the following
  // falling edge, where the registered outputs already reflect it.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_gate",  64'(voice_gate), 64'h0);
    check("rst_freq",  64'(voice_freq), 64'h0001_0001_0001_0001);
    check("rst_key",   64'(voice_key), 64'h0);
    check("rst_count", 64'(active_count), 64'd0);
    check("rst_steal", 64'(steal_pulse), 64'd0);

    // Basic allocation
    send(8'h1C); send(8'h2B); send(8'h33);
    check("alloc_gate",  64'(voice_gate), 64'b0111);
    check("alloc_f0",    64'(vf(0)), 64'd423);
    check("alloc_f1",    64'(vf(1)), 64'd565);
    check("alloc_f2",    64'(vf(2)), 64'd712);
    check("alloc_f3",    64'(vf(3)), 64'd1);
    check("alloc_k2",    64'(vk(2)), 64'h33);
    check("alloc_count", 64'(active_count), 64'd3);

    // Typematic repeat then release
    send(8'h1C); send(8'h1C);
    check("rep_gate",  64'(voice_gate), 64'b0111);
    check("rep_f0",    64'(vf(0)), 64'd423);
    check("rep_f3",    64'(vf(3)), 64'd1);
    check("rep_count", 64'(active_count), 64'd3);
    send(8'hF0); send(8'h1C);
    check("rel_gate",  64'(voice_gate), 64'b0110);
    check("rel_f0",    64'(vf(0)), 64'd1);
    check("rel_k0",    64'(vk(0)), 64'h0);
    check("rel_count", 64'(active_count), 64'd2);
    send(8'h15);
    check("refill_low_f0", 64'(vf(0)), 64'd400);

    // Voice stealing
    do_reset();
    send(8'h15); send(8'h1C); send(8'h1D); send(8'h1B);
    check("full_gate",  64'(voice_gate), 64'b1111);
    check("full_steal", 64'(steal_pulse), 64'd0);
    send(8'h24);
    check("steal1_pulse", 64'(steal_pulse), 64'd1);
    check("steal1_f0",    64'(vf(0)), 64'd503);
    check("steal1_k0",    64'(vk(0)), 64'h24);
    check("steal1_f1",    64'(vf(1)), 64'd423);
    check("steal1_count", 64'(active_count), 64'd4);
    @(negedge clk);
    check("steal1_pulse_end", 64'(steal_pulse), 64'd0);
    send(8'h23);
    check("steal2_f1",    64'(vf(1)), 64'd533);
    check("steal2_k1",    64'(vk(1)), 64'h23);
    check("steal2_f0",    64'(vf(0)), 64'd503);
    check("steal2_f2",    64'(vf(2)), 64'd448);

    // Transpose
    do_reset();
    transpose = 2'b01;
    send(8'h5B);
    check("tr_up_f0", 64'(vf(0)), 64'd2396);
    transpose = 2'b10;
    send(8'h4D);
    check("tr_dn_f1",   64'(vf(1)), 64'd503);
    check("tr_hold_f0", 64'(vf(0)), 64'd2396);
    transpose = 2'b11;
    send(8'h15);
    check("tr_11_f2", 64'(vf(2)), 64'd400);
    transpose = 2'b00;

    // Extended / break sequences produce no events
    do_reset();
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h11);
    send(8'hE0); send(8'h1C);
    check("ext_gate",  64'(voice_gate), 64'h0);
    check("ext_count", 64'(active_count), 64'd0);
    send(8'hF0); send(8'hF0); send(8'h2B);
    check("brk_ign_gate", 64'(voice_gate), 64'h0);
    send(8'h2B);
    check("after_brk_f0",   64'(vf(0)), 64'd565);
    check("after_brk_gate", 64'(voice_gate), 64'b0001);
    send(8'hE0); send(8'hF0); send(8'h2B);
    check("ext_brk_keep", 64'(voice_gate), 64'b0001);

    // all_off discards the concurrent byte
    do_reset();
    send(8'h15); send(8'h1C); send(8'h1D);
    check("pre_off_count", 64'(active_count), 64'd3);
    @(negedge clk);
    scan_code  = 8'h42;
    scan_valid = 1'b1;
    all_off    = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    all_off    = 1'b0;
    check("off_gate",  64'(voice_gate), 64'h0);
    check("off_freq",  64'(voice_freq), 64'h0001_0001_0001_0001);
    check("off_key",   64'(voice_key), 64'h0);
    check("off_count", 64'(active_count), 64'd0);

    // Reset mid-break: next byte is fresh
    send(8'hF0);
    do_reset();
    send(8'h34);
    check("rst_mid_f0",   64'(vf(0)), 64'd634);
    check("rst_mid_gate", 64'(voice_gate), 64'b0001);
    check("rst_mid_k0",   64'(vk(0)), 64'h34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
